tile_map_ctrl: RTL and testbench
================================

TILE_MAP_CTRL -- requirements
Module: tile_map_ctrl

Interface
REQ-001 Parameter TILE_COLS, default 80, tiles per row.
REQ-002 Parameter TILE_ROWS, default 60, tiles per column; MAP_SIZE = TILE_COLS*TILE_ROWS = 4800.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_op  input  2  00 PUT, 01 SETCUR, 10 CLEAR, 11 SCROLL.
REQ-008 cmd_data  input  13  tile byte in [7:0] (PUT/CLEAR/SCROLL) or cursor address (SETCUR).
REQ-009 busy  output  1  multi-cycle operation in progress.
REQ-010 cursor  output  13  current write address, 0..MAP_SIZE-1.
REQ-011 vid_addr  input  13  tile-map address from background engine (col + row*TILE_COLS).
REQ-012 vid_data  output  8  tile byte for vid_addr: [3:0] tile column, [7:4] tile row in tile sheet.

Function
REQ-013 Storage SHALL be MAP_SIZE x 8-bit true dual-port RAM; port A video read-only, port B controller read/write.
REQ-014 vid_data SHALL be registered, valid exactly 1 cycle after vid_addr, independent of controller state.
REQ-015 On same-address collision, port A SHALL return the pre-write byte.
REQ-016 FSM states: IDLE, FILL, COPY, FILL_ROW; cmd_ready = (state==IDLE); busy = ~cmd_ready.
REQ-017 PUT: write cmd_data[7:0] at cursor in the accept cycle; cursor+1 next cycle; stay IDLE.
REQ-018 SETCUR: cursor = cmd_data if < MAP_SIZE, else cursor = 0; no RAM write.
REQ-019 CLEAR: IDLE->FILL; write fill byte to addresses 0..MAP_SIZE-1, one per cycle (4800 cycles); cursor = 0; ->IDLE after last write.
REQ-020 SCROLL: IDLE->COPY; for a = 0..MAP_SIZE-TILE_COLS-1, read a+TILE_COLS, write a one cycle later (pipelined, 1 word/cycle, 4720 writes + 1 fill cycle); ->FILL_ROW; write fill byte to last row (80 cycles); ->IDLE.
REQ-021 SCROLL cursor: cursor -= TILE_COLS if cursor >= TILE_COLS, else unchanged.
REQ-022 Fill byte SHALL be latched at accept; cmd_data changes during busy SHALL be ignored.
REQ-023 cmd_valid while busy SHALL be held off (no accept, no side effect).
REQ-024 Address counters SHALL be 13-bit; no counter SHALL exceed MAP_SIZE-1.

Reset
REQ-025 rst_n low SHALL force state IDLE, cursor 0, vid_data 0, cmd_ready 1 after deassertion, busy 0, internal counters 0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Reset mid-CLEAR/SCROLL SHALL abort immediately; partially written map is left as-is.

Configuration
REQ-028 Macro TILE_AUTO_SCROLL_EN defined: PUT at cursor MAP_SIZE-1 SHALL write, then start SCROLL with fill byte 0x00, cursor ends at MAP_SIZE-TILE_COLS.
REQ-029 Macro undefined: PUT at cursor MAP_SIZE-1 SHALL write, cursor wraps to 0, stay IDLE.

Structure
REQ-030 Shared package tile_pkg SHALL hold TILE_COLS, TILE_ROWS, MAP_SIZE, TILE_WIDTH/HEIGHT (8), cmd_op encodings, FSM state encoding.
REQ-031 RAM SHALL be sub-module tile_ram (true dual-port, registered reads, 4800x8); FSM and cursor in tile_map_ctrl.

Verification
REQ-032 Reset then PUT 0x21 at cursor 0 -> vid_addr 0 gives vid_data 0x21 one cycle later; cursor = 1.
REQ-033 SETCUR 4799 then PUT 0x5A -> without macro cursor = 0, cmd_ready 1; with TILE_AUTO_SCROLL_EN busy for 4801 cycles, addr 4719 = 0x5A, addr 4799 = 0x00, cursor = 4720.
REQ-034 SETCUR 6000 -> cursor = 0; no RAM change.
REQ-035 CLEAR 0x0F -> busy exactly 4800 cycles, cmd held off during busy, all 4800 addresses read 0x0F, cursor 0.
REQ-036 Map addr n = n[7:0], SCROLL fill 0x00 -> addr 0 = 80, addr 4719 = 4799[7:0] = 0xBF, addrs 4720..4799 = 0x00; cursor 100 -> 20.
REQ-037 rst_n low at cycle 2000 of CLEAR 0xAA -> busy 0 immediately, addrs 0..~1999 = 0xAA, rest unchanged, cursor 0.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared constants, command encodings and FSM states for the tile map.
// Optional feature macro: TILE_AUTO_SCROLL_EN (auto-scroll on PUT at last cell).
package tile_pkg;

    localparam int TILE_COLS   = 80;
    localparam int TILE_ROWS   = 60;
    localparam int MAP_SIZE    = TILE_COLS * TILE_ROWS;
    localparam int TILE_WIDTH  = 8;
    localparam int TILE_HEIGHT = 8;
    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        OP_PUT    = 2'b00,
        OP_SETCUR = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_SCROLL = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FILL     = 2'b01,
        ST_COPY     = 2'b10,
        ST_FILL_ROW = 2'b11
    } state_e;

endpackage

// File: rtl/tile_ram.sv
// Tile map storage: port A video read, port B controller write plus read.
// Both read ports are registered; a same-cycle write is seen one access later.
import tile_pkg::*;

module tile_ram #(
    parameter int DEPTH = MAP_SIZE,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a_addr_i,
    output logic [DW-1:0] a_data_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_waddr_i,
    input  logic [DW-1:0] b_wdata_i,
    input  logic [AW-1:0] b_raddr_i,
    output logic [DW-1:0] b_rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] a_data_q;
    logic [DW-1:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (b_we_i && (b_waddr_i < AW'(DEPTH))) begin
            mem_q[b_waddr_i] <= b_wdata_i;
        end
    end

    // Contents are never reset; only the read registers are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_q  <= '0;
            b_rdata_q <= '0;
        end else begin
            a_data_q  <= (a_addr_i < AW'(DEPTH)) ? mem_q[a_addr_i] : '0;
            b_rdata_q <= (b_raddr_i < AW'(DEPTH)) ? mem_q[b_raddr_i] : '0;
        end
    end

    assign a_data_o  = a_data_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map controller: command FSM (PUT/SETCUR/CLEAR/SCROLL) and cursor.
// Define TILE_AUTO_SCROLL_EN to scroll automatically on PUT at the last cell.
import tile_pkg::*;

module tile_map_ctrl #(
    parameter int TILE_COLS = tile_pkg::TILE_COLS,
    parameter int TILE_ROWS = tile_pkg::TILE_ROWS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_data,
    output logic        busy,
    output logic [12:0] cursor,
    input  logic [12:0] vid_addr,
    output logic [7:0]  vid_data
);

    localparam int          MSZ      = TILE_COLS * TILE_ROWS;
    localparam logic [12:0] LAST     = 13'(MSZ - 1);
    localparam logic [12:0] COLS     = 13'(TILE_COLS);
    localparam logic [12:0] COPY_END = 13'(MSZ - TILE_COLS);

    state_e      state_q, state_d;
    logic [12:0] cursor_q, cursor_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  fill_q, fill_d;

    cmd_op_e     op;
    logic        acc;
    logic        wrap;

    logic        ram_we;
    logic [12:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic [12:0] ram_raddr;
    logic [7:0]  ram_rdata;

    assign op   = cmd_op_e'(cmd_op);
    assign acc  = cmd_valid && (state_q == ST_IDLE);
    assign wrap = (cursor_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            cnt_q    <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    unique case (op)
                        OP_CLEAR:  state_d = ST_FILL;
                        OP_SCROLL: state_d = ST_COPY;
`ifdef TILE_AUTO_SCROLL_EN
                        OP_PUT:    state_d = wrap ? ST_COPY : ST_IDLE;
`endif
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_FILL:     if (cnt_q == LAST) state_d = ST_IDLE;
            ST_COPY:     if (cnt_q == COPY_END) state_d = ST_FILL_ROW;
            ST_FILL_ROW: if (cnt_q == LAST) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cursor_d = cursor_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    unique case (op)
                        OP_PUT: begin
`ifdef TILE_AUTO_SCROLL_EN
                            cursor_d = wrap ? COPY_END : cursor_q + 13'd1;
                            fill_d   = wrap ? 8'h00 : fill_q;
                            cnt_d    = '0;
`else
                            cursor_d = wrap ? 13'd0 : cursor_q + 13'd1;
`endif
                        end
                        OP_SETCUR: begin
                            cursor_d = (cmd_data <= LAST) ? cmd_data : 13'd0;
                        end
                        OP_CLEAR: begin
                            fill_d   = cmd_data[7:0];
                            cursor_d = '0;
                            cnt_d    = '0;
                        end
                        OP_SCROLL: begin
                            fill_d   = cmd_data[7:0];
                            cnt_d    = '0;
                            if (cursor_q >= COLS) cursor_d = cursor_q - COLS;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL, ST_FILL_ROW: begin
                cnt_d = (cnt_q == LAST) ? 13'd0 : cnt_q + 13'd1;
            end
            // The last copy cycle hands its count straight to the row fill.
            ST_COPY: begin
                cnt_d = (cnt_q == COPY_END) ? COPY_END : cnt_q + 13'd1;
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = ~cmd_ready;
        ram_we    = 1'b0;
        ram_waddr = cursor_q;
        ram_wdata = cmd_data[7:0];
        ram_raddr = '0;
        unique case (state_q)
            ST_IDLE: begin
                ram_we = acc && (op == OP_PUT);
            end
            ST_FILL, ST_FILL_ROW: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = fill_q;
            end
            // Read a+COLS now, write the word read last cycle to a-1.
            ST_COPY: begin
                ram_raddr = (cnt_q == COPY_END) ? 13'd0 : cnt_q + COLS;
                ram_we    = (cnt_q != 13'd0);
                ram_waddr = cnt_q - 13'd1;
                ram_wdata = ram_rdata;
            end
            default: ;
        endcase
    end

    assign cursor = cursor_q;

    tile_ram #(
        .DEPTH (MSZ),
        .AW    (13),
        .DW    (8)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_addr_i  (vid_addr),
        .a_data_o  (vid_data),
        .b_we_i    (ram_we),
        .b_waddr_i (ram_waddr),
        .b_wdata_i (ram_wdata),
        .b_raddr_i (ram_raddr),
        .b_rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Scoreboard bench for tile_map_ctrl: video reads are queued with expected
// bytes and checked by a monitor; control outputs are checked directly.
module tb_tile_map_ctrl;

    localparam int MS = 4800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [12:0] cmd_data;
    logic        busy;
    logic [12:0] cursor;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;

    logic        vid_req;
    logic        pend;

    typedef struct {
        int       addr;
        logic [7:0] d;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] m [MS];

    int vectors;
    int miscompares;

    tile_map_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .cursor    (cursor),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pend <= vid_req;

    always @(negedge clk) begin
        if (pend) begin
            exp_t e;
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL vid_data: unexpected output %02h, no entry queued",
                         vid_data);
            end else begin
                e = sbq.pop_front();
                if (vid_data !== e.d) begin
                    miscompares++;
                    $display("FAIL vid_data addr=%0d got %02h expected %02h",
                             e.addr, vid_data, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [12:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle timeout busy=%0b", busy);
        end
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        exp_t x;
        x.addr = a;
        x.d    = e;
        sbq.push_back(x);
        vid_req  = 1'b1;
        vid_addr = 13'(a);
        @(posedge clk);
        #1;
        vid_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int a = 0; a < MS; a++) rd(a, m[a]);
    endtask

    task automatic m_scroll(input logic [7:0] f);
        for (int a = 0; a < MS - 80; a++) m[a] = m[a + 80];
        for (int a = MS - 80; a < MS; a++) m[a] = f;
    endtask

    initial begin
        int n;
        exp_t x;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset cursor", int'(cursor), 0);
        chk("reset vid_data", int'(vid_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // CLEAR with a command held against it mid-operation
        cmd(2'b10, 13'h00F);
        n = 0;
        while (busy && n < 20000) begin
            if (n == 10) begin
                chk("holdoff cmd_ready", int'(cmd_ready), 0);
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                cmd_data  = 13'h077;
            end
            if (n == 100) cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        chk("clear busy cycles", n, 4800);
        chk("clear cursor", int'(cursor), 0);
        chk("clear ready", int'(cmd_ready), 1);
        for (int a = 0; a < MS; a++) m[a] = 8'h0F;
        rd_all();

        cmd(2'b00, 13'h021);
        m[0] = 8'h21;
        chk("put cursor", int'(cursor), 1);
        rd(0, 8'h21);

        cmd(2'b01, 13'd6000);
        chk("setcur oob cursor", int'(cursor), 0);
        rd(0, 8'h21);
        rd(1, 8'h0F);

        // PUT and video read of the same address in one cycle
        cmd(2'b01, 13'd5);
        x.addr = 5;
        x.d    = 8'h0F;
        sbq.push_back(x);
        vid_req   = 1'b1;
        vid_addr  = 13'd5;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 13'h033;
        @(posedge clk);
        #1;
        vid_req   = 1'b0;
        cmd_valid = 1'b0;
        m[5] = 8'h33;
        rd(5, 8'h33);

        cmd(2'b01, 13'd4799);
        chk("setcur last", int'(cursor), 4799);
        cmd(2'b00, 13'h05A);
        m[4799] = 8'h5A;
`ifdef TILE_AUTO_SCROLL_EN
        wait_idle(n);
        chk("autoscroll busy", n, 4801);
        chk("autoscroll cursor", int'(cursor), 4720);
        m_scroll(8'h00);
        rd(4719, 8'h5A);
        rd(4799, 8'h00);
`else
        chk("wrap cursor", int'(cursor), 0);
        chk("wrap ready", int'(cmd_ready), 1);
        rd(4799, 8'h5A);
`endif

        // Map address n holds n[7:0], then scroll with fill 0
        cmd(2'b01, 13'd0);
        for (int a = 0; a < MS - 1; a++) begin
            cmd(2'b00, 13'(a & 8'hFF));
            m[a] = 8'(a);
        end
`ifndef TILE_AUTO_SCROLL_EN
        cmd(2'b00, 13'h0BF);
        m[4799] = 8'hBF;
        chk("fill wrap cursor", int'(cursor), 0);
`endif
        cmd(2'b01, 13'd100);
        cmd(2'b11, 13'h000);
        wait_idle(n);
        chk("scroll busy", n, 4801);
        chk("scroll cursor", int'(cursor), 20);
        m_scroll(8'h00);
        rd(0, 8'd80);
`ifndef TILE_AUTO_SCROLL_EN
        rd(4719, 8'hBF);
`endif
        rd(4750, 8'h00);
        rd_all();

        cmd(2'b01, 13'd50);
        cmd(2'b11, 13'h000);
        wait_idle(n);
        chk("scroll small cursor", int'(cursor), 50);
        m_scroll(8'h00);

        // Reset during CLEAR aborts; earlier writes stay
        cmd(2'b10, 13'h0AA);
        repeat (2000) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort cursor", int'(cursor), 0);
        chk("abort vid_data", int'(vid_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ready", int'(cmd_ready), 1);
        for (int a = 0; a < 2000; a++) m[a] = 8'hAA;
        rd(1999, 8'hAA);
        rd(2000, m[2000]);
        rd_all();

        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
